// File: rtl/int_addsub_pkg.sv
// int_addsub_pkg: shared FSM states, op encodings and sizing helpers for the
// digit-serial integer add/sub datapath.
package int_addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;
    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational SLICE-bit ripple add/sub (B inverted when sub=1);
// c_msb is the carry into the top bit, used for signed overflow detection.
module addsub_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [SLICE-1:0] bx;
    logic [SLICE:0]   c;
    assign bx = b ^ {SLICE{sub}};
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end
    assign cout  = c[SLICE];
    assign c_msb = c[SLICE-1];
endmodule

// File: rtl/int_addsub_seq.sv
// int_addsub_seq: digit-serial adder/subtractor, one SLICE-bit slice per cycle.
// Define INT_ADDSUB_OVF_EN to compute signed overflow; otherwise ovf is tied to 0.
module int_addsub_seq
    import int_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("int_addsub_seq: WIDTH must be a multiple of SLICE");
    end

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r;
    logic             sub_r, carry;
    logic [IW-1:0]    idx;
    logic [SLICE-1:0] ss;
    logic             sc, c_msb, last;

    assign last = (idx == LAST);

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_r[int'(idx)*SLICE +: SLICE]),
        .b    (b_r[int'(idx)*SLICE +: SLICE]),
        .sub  (sub_r),
        .cin  (carry),
        .s    (ss),
        .cout (sc),
        .c_msb(c_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sub_r     <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r      <= a;
                    b_r      <= b;
                    sub_r    <= sub;
                    carry    <= (sub == OP_SUB);
                    idx      <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    sum[int'(idx)*SLICE +: SLICE] <= ss;
                    carry <= sc;
                    idx   <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        cout      <= sc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INT_ADDSUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (state == RUN && last)
            ovf <= c_msb ^ sc;
    end
`else
    logic unused_c_msb;
    assign unused_c_msb = c_msb;
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_int_addsub_seq.sv
// tb_int_addsub_seq: directed self-checking bench for int_addsub_seq (defaults WIDTH=32, SLICE=8).
module tb_int_addsub_seq;
`ifdef INT_ADDSUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          errors = 0;
    int          checks = 0;

    int_addsub_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                         output logic [31:0] rs, output logic rc, output logic ro, output int lat);
        int n;
        a = ta; b = tbv; sub = ts; in_valid = 1'b1; n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0; lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rs = sum; rc = cout; ro = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset sum got=%h exp=0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset cout got=%b exp=0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf got=%b exp=0", ovf); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_wrap();
        a = 32'hFFFFFFFF; b = 32'h1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL add_run cyc=%0d out_valid=%b in_ready=%b exp 0/0", i, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency out_valid got=%b exp=1 at 4 cycles", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_done in_ready got=%b exp=0", in_ready); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL add_sum got=%h exp=00000000", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL add_cout got=%b exp=1", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf got=%b exp=0", ovf); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL add_handshake out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub();
        logic [31:0] rs; logic rc, ro; int lat;
        do_op(32'd5, 32'd7, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 32'hFFFFFFFE || rc !== 1'b0) begin
            errors++; $display("FAIL sub_5_7 got sum=%h cout=%b exp sum=fffffffe cout=0", rs, rc);
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency got=%0d exp=4", lat); end
        do_op(32'd7, 32'd5, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 32'h2 || rc !== 1'b1) begin
            errors++; $display("FAIL sub_7_5 got sum=%h cout=%b exp sum=00000002 cout=1", rs, rc);
        end
    endtask

    task automatic test_ovf();
        logic [31:0] rs; logic rc, ro; int lat;
        do_op(32'h7FFFFFFF, 32'h1, 1'b0, rs, rc, ro, lat);
        checks++; if (rs !== 32'h80000000 || ro !== OVF_ON) begin
            errors++; $display("FAIL ovf_maxpos got sum=%h ovf=%b exp sum=80000000 ovf=%b", rs, ro, OVF_ON);
        end
        do_op(32'h80000000, 32'h1, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 32'h7FFFFFFF || rc !== 1'b1 || ro !== OVF_ON) begin
            errors++; $display("FAIL ovf_minneg got sum=%h cout=%b ovf=%b exp sum=7fffffff cout=1 ovf=%b", rs, rc, ro, OVF_ON);
        end
        do_op(32'd3, 32'd4, 1'b0, rs, rc, ro, lat);
        checks++; if (rs !== 32'd7 || ro !== 1'b0) begin
            errors++; $display("FAIL ovf_small got sum=%h ovf=%b exp sum=00000007 ovf=0", rs, ro);
        end
    endtask

    task automatic test_backpressure();
        int n;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle in_ready got=%b exp=1", in_ready); end
        a = 32'h12345678; b = 32'h11111111; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'hDEADBEEF; b = 32'h0BADF00D; sub = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", n); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (sum !== 32'h23456789 || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d sum=%h cout=%b out_valid=%b in_ready=%b exp 23456789/0/1/0",
                                   i, sum, cout, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        a = 32'd1; b = 32'd2; sub = 1'b0; out_ready = 1'b1;
        checks++; if (sum !== 32'h23456789) begin errors++; $display("FAIL bp_final sum got=%h exp=23456789", sum); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept in_ready got=%b exp=0", in_ready); end
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 4 || sum !== 32'd3 || cout !== 1'b0) begin
            errors++; $display("FAIL bp_next got lat=%0d sum=%h cout=%b exp 4/00000003/0", n, sum, cout);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rs; logic rc, ro; int lat;
        a = 32'hFFFFFFFF; b = 32'h1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst handshake out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        checks++; if (sum !== 32'h0 || cout !== 1'b0) begin
            errors++; $display("FAIL midrst outputs sum=%h cout=%b exp 00000000/0", sum, cout);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(32'd10, 32'd20, 1'b0, rs, rc, ro, lat);
        checks++; if (rs !== 32'd30 || rc !== 1'b0 || lat !== 4) begin
            errors++; $display("FAIL midrst_next got sum=%h cout=%b lat=%0d exp 0000001e/0/4", rs, rc, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] opa [3] = '{32'd1, 32'd100, 32'd0};
        logic [31:0] opb [3] = '{32'd2, 32'd50, 32'd1};
        logic        ops [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] esum[3] = '{32'd3, 32'd50, 32'hFFFFFFFF};
        logic        ecy [3] = '{1'b0, 1'b1, 1'b0};
        int acc[3];
        int ki = 0, ko = 0, overlap = 0;
        a = opa[0]; b = opb[0]; sub = ops[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (in_ready && out_valid) overlap++;
            if (out_valid) begin
                if (ko < 3) begin
                    checks++;
                    if (sum !== esum[ko] || cout !== ecy[ko]) begin
                        errors++; $display("FAIL b2b_result op=%0d got sum=%h cout=%b exp sum=%h cout=%b",
                                           ko, sum, cout, esum[ko], ecy[ko]);
                    end
                end
                ko++;
            end
            if (in_ready && in_valid && ki < 3) begin acc[ki] = cyc; ki++; end
            @(posedge clk); #1;
            if (ki < 3) begin a = opa[ki]; b = opb[ki]; sub = ops[ki]; end
            else in_valid = 1'b0;
        end
        out_ready = 1'b0;
        checks++; if (ko !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", ko); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap got=%0d exp=0", overlap); end
        checks++; if (acc[1] - acc[0] !== 6) begin errors++; $display("FAIL b2b_spacing1 got=%0d exp=6", acc[1] - acc[0]); end
        checks++; if (acc[2] - acc[1] !== 6) begin errors++; $display("FAIL b2b_spacing2 got=%0d exp=6", acc[2] - acc[1]); end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub();
        test_ovf();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
